// File: rtl/keypad_scanner.sv
// keypad_scanner: row-scanned key matrix with per-key scan-count debounce and an event FIFO.
// Define KEYPAD_RELEASE_EVENTS_EN to also queue release events.
module keypad_scanner #(
   parameter int ROWS         = 4,
   parameter int COLS         = 4,
   parameter int SETTLE_TICKS = 8,
   parameter int STABLE_SCANS = 4,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic                         in_clk,
   input  logic                         in_rst,
   output logic [ROWS-1:0]              out_rows,
   input  logic [COLS-1:0]              in_cols,
   output logic                         out_key_valid,
   input  logic                         in_key_ready,
   output logic [$clog2(ROWS*COLS)-1:0] out_key_idx,
   output logic                         out_key_pressed,
   output logic [ROWS*COLS-1:0]         out_keys,
   output logic                         out_overflow,
   input  logic                         in_clr_overflow
);
   localparam int NK = ROWS * COLS;
   localparam int IW = $clog2(NK);
   localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam int LW = (COLS > 1) ? $clog2(COLS) : 1;
   localparam int SW = $clog2(SETTLE_TICKS);
   localparam int CW = $clog2(STABLE_SCANS + 1);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int EW = IW + 1;

   localparam logic [1:0] S_DRIVE  = 2'd0;
   localparam logic [1:0] S_SETTLE = 2'd1;
   localparam logic [1:0] S_SAMPLE = 2'd2;
   localparam logic [1:0] S_EMIT   = 2'd3;

`ifdef KEYPAD_RELEASE_EVENTS_EN
   localparam logic REL = 1'b1;
`else
   localparam logic REL = 1'b0;
`endif

   logic [COLS-1:0] sync1_q, sync1_d, sync2_q, sync2_d, sample_q, sample_d;
   logic [1:0]      state_q, state_d;
   logic [RW-1:0]   row_q, row_d;
   logic [LW-1:0]   col_q, col_d;
   logic [SW-1:0]   settle_q, settle_d;
   logic [ROWS-1:0] rows_q, rows_d;
   logic [NK-1:0]   keys_q, keys_d;
   logic [CW-1:0]   cnt_q [NK];
   logic [CW-1:0]   cnt_d [NK];
   logic [EW-1:0]   mem_q [FIFO_DEPTH];
   logic [EW-1:0]   mem_d [FIFO_DEPTH];
   logic [PW-1:0]   wr_q, wr_d, rd_q, rd_d;
   logic [PW:0]     count_q, count_d;
   logic            ovf_q, ovf_d;
   logic [IW-1:0]   key_idx;
   logic            key_smp, push, pop, full, accept, drop;
   logic [EW-1:0]   push_data, head;

   assign key_idx = IW'(int'(row_q) * COLS + int'(col_q));
   assign key_smp = sample_q[col_q];

   always_comb begin
      sync1_d   = ~in_cols;
      sync2_d   = sync1_q;
      state_d   = state_q;
      row_d     = row_q;
      col_d     = col_q;
      settle_d  = settle_q;
      sample_d  = sample_q;
      rows_d    = rows_q;
      keys_d    = keys_q;
      cnt_d     = cnt_q;
      push      = 1'b0;
      push_data = {key_idx, key_smp};
      case (state_q)
         S_DRIVE: begin
            rows_d   = ~(ROWS'(1) << row_q);
            settle_d = '0;
            state_d  = S_SETTLE;
         end
         S_SETTLE: begin
            settle_d = settle_q + 1'b1;
            if (settle_q == SW'(SETTLE_TICKS - 1)) state_d = S_SAMPLE;
         end
         S_SAMPLE: begin
            sample_d = sync2_q;
            col_d    = '0;
            state_d  = S_EMIT;
         end
         default: begin
            if (key_smp == keys_q[key_idx]) cnt_d[key_idx] = '0;
            else if (cnt_q[key_idx] == CW'(STABLE_SCANS - 1)) begin
               keys_d[key_idx] = key_smp;
               cnt_d[key_idx]  = '0;
               push            = key_smp | REL;
            end else cnt_d[key_idx] = cnt_q[key_idx] + 1'b1;
            col_d = col_q + 1'b1;
            if (col_q == LW'(COLS - 1)) begin
               col_d   = '0;
               state_d = S_DRIVE;
               row_d   = (row_q == RW'(ROWS - 1)) ? '0 : row_q + 1'b1;
            end
         end
      endcase
   end

   // A full FIFO still accepts a push when the head is popped in the same cycle.
   always_comb begin
      pop     = out_key_valid & in_key_ready;
      full    = count_q == (PW+1)'(FIFO_DEPTH);
      accept  = push & (~full | pop);
      drop    = push & ~accept;
      count_d = count_q + (PW+1)'(accept) - (PW+1)'(pop);
      wr_d    = accept ? wr_q + 1'b1 : wr_q;
      rd_d    = pop ? rd_q + 1'b1 : rd_q;
      ovf_d   = drop | (ovf_q & ~in_clr_overflow);
      mem_d   = mem_q;
      if (accept) mem_d[wr_q] = push_data;
   end

   always_ff @(posedge in_clk or negedge in_rst) begin
      if (!in_rst) begin
         sync1_q  <= '0;
         sync2_q  <= '0;
         sample_q <= '0;
         state_q  <= S_DRIVE;
         row_q    <= '0;
         col_q    <= '0;
         settle_q <= '0;
         rows_q   <= '1;
         keys_q   <= '0;
         cnt_q    <= '{default: '0};
         mem_q    <= '{default: '0};
         wr_q     <= '0;
         rd_q     <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
      end else begin
         sync1_q  <= sync1_d;
         sync2_q  <= sync2_d;
         sample_q <= sample_d;
         state_q  <= state_d;
         row_q    <= row_d;
         col_q    <= col_d;
         settle_q <= settle_d;
         rows_q   <= rows_d;
         keys_q   <= keys_d;
         cnt_q    <= cnt_d;
         mem_q    <= mem_d;
         wr_q     <= wr_d;
         rd_q     <= rd_d;
         count_q  <= count_d;
         ovf_q    <= ovf_d;
      end
   end

   assign head            = mem_q[rd_q];
   assign out_rows        = rows_q;
   assign out_keys        = keys_q;
   assign out_overflow    = ovf_q;
   assign out_key_valid   = count_q != '0;
   assign out_key_idx     = head[EW-1:1];
   assign out_key_pressed = REL ? head[0] : 1'b1;
endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed key-matrix stimulus against a scan-level behavioural model.
// Honours KEYPAD_RELEASE_EVENTS_EN like the design.
module tb_keypad_scanner;
   localparam int R = 4, C = 4, ST = 8, SS = 4, FD = 4;
   localparam int RP = 2 + ST + C;
   localparam int SP = R * RP;
   localparam int EMIT0 = 2 + ST;
`ifdef KEYPAD_RELEASE_EVENTS_EN
   localparam bit REL = 1'b1;
`else
   localparam bit REL = 1'b0;
`endif

   typedef struct packed { logic [3:0] idx; logic p; } ev_t;

   logic clk = 1'b0, rst_n = 1'b0, ready = 1'b0, clr = 1'b0;
   logic [R-1:0] rows;
   logic [C-1:0] cols;
   logic valid, pressed, ovf;
   logic [3:0] idx;
   logic [R*C-1:0] keys, key_mat = '0;
   int cyc, checks = 0, errors = 0, s;

   logic [R*C-1:0] m_keys, mat_prev;
   int m_cnt [R*C];
   logic [C-1:0] m_samp [R];
   ev_t m_q[$], log_q[$];
   logic m_ovf, rdy_prev, clr_prev;

   always #5 clk = ~clk;

   // Ideal passive matrix: a column reads low when a closed key joins it to a driven row.
   always_comb begin
      cols = '1;
      for (int r = 0; r < R; r++)
         for (int c = 0; c < C; c++)
            if (!rows[r] && key_mat[r*C+c]) cols[c] = 1'b0;
   end

   keypad_scanner dut (
      .in_clk(clk), .in_rst(rst_n), .out_rows(rows), .in_cols(cols),
      .out_key_valid(valid), .in_key_ready(ready), .out_key_idx(idx),
      .out_key_pressed(pressed), .out_keys(keys), .out_overflow(ovf),
      .in_clr_overflow(clr)
   );

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) cyc <= 0;
      else cyc <= cyc + 1;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
      end
   endtask

   // cyc counts edges since reset release; the model replays cycle cyc-1 from row/column arithmetic.
   always @(negedge clk) begin : cmp
      int c, off, r, k;
      logic sm, push, drop;
      ev_t e;
      logic [R-1:0] exp_rows;
      if (!rst_n) begin
         m_keys = '0;
         m_ovf  = 1'b0;
         m_q.delete();
         for (int i = 0; i < R*C; i++) m_cnt[i] = 0;
         for (int i = 0; i < R; i++) m_samp[i] = '0;
      end else if (cyc >= 1) begin
         c = cyc - 1;
         off = c % RP;
         r = (c / RP) % R;
         push = 1'b0;
         drop = 1'b0;
         e = '0;
         if (off == EMIT0 - 1) m_samp[r] = mat_prev[r*C +: C];
         if (off >= EMIT0) begin
            k = r*C + off - EMIT0;
            sm = m_samp[r][off-EMIT0];
            if (sm == m_keys[k]) m_cnt[k] = 0;
            else if (m_cnt[k] == SS - 1) begin
               m_keys[k] = sm;
               m_cnt[k] = 0;
               push = sm || REL;
               e = {4'(k), sm};
            end else m_cnt[k]++;
         end
         if (m_q.size() > 0 && rdy_prev) void'(m_q.pop_front());
         if (push) begin
            if (m_q.size() < FD) m_q.push_back(e);
            else drop = 1'b1;
         end
         if (drop) m_ovf = 1'b1;
         else if (clr_prev) m_ovf = 1'b0;
         exp_rows = ~(R'(1) << r);
         chk("rows", rows, exp_rows);
         chk("keys", keys, m_keys);
         chk("valid", valid, m_q.size() != 0);
         if (m_q.size() != 0) begin
            chk("idx", idx, m_q[0].idx);
            chk("pressed", pressed, m_q[0].p);
         end
         chk("overflow", ovf, m_ovf);
         if (valid && ready) log_q.push_back({idx, pressed});
      end
      mat_prev = key_mat;
      rdy_prev = ready;
      clr_prev = clr;
   end

   task automatic wait_cyc(input int n);
      while (cyc < n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic next_scan(output int st);
      do begin
         @(posedge clk);
         #1;
      end while (cyc % SP != 0);
      st = cyc;
   endtask

   function automatic logic [31:0] log_ids();
      logic [31:0] v = 0;
      foreach (log_q[i]) v = (v << 4) | 32'(log_q[i].idx);
      return v;
   endfunction

   task automatic do_reset();
      rst_n = 1'b0;
      ready = 1'b0;
      clr = 1'b0;
      key_mat = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_rows", rows, 4'b1111);
      chk("rst_valid", valid, 1'b0);
      chk("rst_keys", keys, 16'h0000);
      chk("rst_ovf", ovf, 1'b0);
      rst_n = 1'b1;
      #1;
      chk("rel_rows", rows, 4'b1111);
      log_q.delete();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      // single key 6 held: reported on the 4th scan that samples it
      do_reset();
      ready = 1'b1;
      next_scan(s);
      key_mat = 16'h0040;
      wait_cyc(s + 3*SP + RP + EMIT0 + 2);
      chk("t2_keys_before", keys[6], 1'b0);
      chk("t2_valid_before", valid, 1'b0);
      wait_cyc(s + 3*SP + RP + EMIT0 + 3);
      chk("t2_keys_after", keys[6], 1'b1);
      chk("t2_valid", valid, 1'b1);
      chk("t2_idx", idx, 4'd6);
      chk("t2_pressed", pressed, 1'b1);
      wait_cyc(cyc + 2*SP);
      chk("t2_count", log_q.size(), 1);
      chk("t2_log", {log_q[0].idx, log_q[0].p}, 5'b01101);
      // chattering key never accumulates enough agreeing scans
      do_reset();
      ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         next_scan(s);
         key_mat = (i % 2 == 0) ? 16'h0040 : 16'h0000;
      end
      next_scan(s);
      key_mat = '0;
      wait_cyc(s + 2*SP);
      chk("t3_keys", keys, 16'h0000);
      chk("t3_count", log_q.size(), 0);
      // press then release key 6
      do_reset();
      ready = 1'b1;
      next_scan(s);
      key_mat = 16'h0040;
      wait_cyc(s + 4*SP);
      key_mat = '0;
      wait_cyc(s + 9*SP);
      chk("t4_keys", keys, 16'h0000);
      chk("t4_count", log_q.size(), REL ? 2 : 1);
      chk("t4_first", {log_q[0].idx, log_q[0].p}, 5'b01101);
      chk("t4_last", {log_q[log_q.size()-1].idx, log_q[log_q.size()-1].p}, REL ? 5'b01100 : 5'b01101);
      // five presses into a four-entry FIFO with ready low
      do_reset();
      next_scan(s);
      key_mat = 16'h002F;
      wait_cyc(s + 3*SP + RP + EMIT0 + 2);
      chk("t5_ovf", ovf, 1'b1);
      chk("t5_valid", valid, 1'b1);
      chk("t5_head", idx, 4'd0);
      chk("t5_keys", keys, 16'h002F);
      ready = 1'b1;
      wait_cyc(cyc + 8);
      chk("t5_count", log_q.size(), 4);
      chk("t5_order", log_ids(), 32'h0123);
      chk("t5_sticky", ovf, 1'b1);
      clr = 1'b1;
      wait_cyc(cyc + 1);
      clr = 1'b0;
      chk("t5_clr", ovf, 1'b0);
      // full FIFO, pop coincides with push
      do_reset();
      next_scan(s);
      key_mat = 16'h001F;
      wait_cyc(s + 3*SP + RP + EMIT0);
      chk("t6_full_head", idx, 4'd0);
      ready = 1'b1;
      wait_cyc(cyc + 1);
      chk("t6_ovf", ovf, 1'b0);
      chk("t6_valid", valid, 1'b1);
      chk("t6_head", idx, 4'd1);
      wait_cyc(cyc + 8);
      chk("t6_count", log_q.size(), 5);
      chk("t6_order", log_ids(), 32'h01234);
      chk("t6_ovf_end", ovf, 1'b0);
      // reset in the middle of SETTLE with events pending
      do_reset();
      next_scan(s);
      key_mat = 16'h000F;
      wait_cyc(s + 3*SP + EMIT0 + 4);
      chk("t1_pending", valid, 1'b1);
      chk("t1_keys_set", keys, 16'h000F);
      while (cyc % RP != 4) begin
         @(posedge clk);
         #1;
      end
      rst_n = 1'b0;
      #1;
      chk("t1_rows", rows, 4'b1111);
      chk("t1_valid", valid, 1'b0);
      chk("t1_keys", keys, 16'h0000);
      repeat (2) @(posedge clk);
      #1;
      key_mat = '0;
      rst_n = 1'b1;
      #1;
      chk("t1_rows_idle", rows, 4'b1111);
      wait_cyc(1);
      chk("t1_row0", rows, 4'b1110);
      wait_cyc(RP + 1);
      chk("t1_row1", rows, 4'b1101);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
